// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
// Optional flag outputs are enabled with PREFIX_ADDER_FLAGS_EN.
package pipelined_prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int calc_latency(input int width, input int reg_every);
        int lv;
        lv = clog2(width);
        return (lv + reg_every - 1) / reg_every + 1;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for the pipelined prefix adder.
// PREFIX_ADDER_FLAGS_EN adds the zero/neg result flags.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 64
);
    import pipelined_prefix_adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic             zero;
    logic             neg;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
`ifdef PREFIX_ADDER_FLAGS_EN
        , input zero, neg
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
`ifdef PREFIX_ADDER_FLAGS_EN
        , output zero, neg
`endif
    );

endinterface

// File: rtl/pipelined_prefix_adder_prefix_cell.sv
// Kogge-Stone black cell: merges a high (g,p) span with the adjacent low span.
module pipelined_prefix_adder_prefix_cell
    import pipelined_prefix_adder_pkg::*;
(
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);

    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined parametrised Kogge-Stone adder/subtractor with valid/ready flow.
// PREFIX_ADDER_FLAGS_EN adds registered zero/neg result flags.
module pipelined_prefix_adder
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_prefix_adder_if.slave bus
);

    localparam int LEVELS  = clog2(WIDTH);
    localparam int LATENCY = calc_latency(WIDTH, REG_EVERY);
    localparam int NG      = LATENCY - 1;

    typedef gp_t [WIDTH-1:0] gpv_t;

    if (WIDTH < 2 || REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_bad_cfg
        $error("pipelined_prefix_adder: bad WIDTH/REG_EVERY");
    end

    gpv_t             r_gp [NG];
    logic [WIDTH-1:0] r_p  [NG];
    logic             r_c0 [NG];
    logic [NG:0]      r_v;
    logic             r_init;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic             r_zero;
    logic             r_neg;
`endif

    logic [NG:0]      w_ld;
    logic             w_take;
    logic             w_c0;
    logic [WIDTH-1:0] w_beff;
    gpv_t             w_gp0;
    gpv_t             w_in  [LEVELS];
    gpv_t             w_out [LEVELS];
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_unused_p;
    logic [WIDTH-1:0] w_sum;

    // A stage may load when empty or when its successor moves on.
    always_comb begin
        w_ld[NG] = ~r_v[NG] | bus.out_ready;
        for (int s = NG - 1; s >= 0; s--) begin
            w_ld[s] = ~r_v[s] | w_ld[s+1];
        end
    end

    assign w_take = bus.in_valid & r_init;
    assign w_c0   = bus.sub | bus.cin;
    assign w_beff = bus.b ^ {WIDTH{bus.sub}};

    // Carry-in folds into bit 0 so LEVELS levels still span the full word.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gp0[i].g = bus.a[i] & w_beff[i];
            w_gp0[i].p = bus.a[i] ^ w_beff[i];
        end
        w_gp0[0].g = w_gp0[0].g | (w_gp0[0].p & w_c0);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        if (k % REG_EVERY == 0) begin : g_src_reg
            assign w_in[k] = r_gp[k / REG_EVERY];
        end else begin : g_src_comb
            assign w_in[k] = w_out[k-1];
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                pipelined_prefix_adder_prefix_cell u_cell (
                    .i_g_hi (w_in[k][i].g),
                    .i_p_hi (w_in[k][i].p),
                    .i_g_lo (w_in[k][i-D].g),
                    .i_p_lo (w_in[k][i-D].p),
                    .o_g    (w_out[k][i].g),
                    .o_p    (w_out[k][i].p)
                );
            end else begin : g_pass
                assign w_out[k][i] = w_in[k][i];
            end
        end
    end

    always_comb begin
        w_c        = '0;
        w_unused_p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i]        = w_out[LEVELS-1][i].g;
            w_unused_p[i] = w_out[LEVELS-1][i].p;
        end
    end

    assign w_sum = r_p[NG-1] ^ {w_c[WIDTH-2:0], r_c0[NG-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
            r_v    <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_ld[0]) r_v[0] <= w_take;
            for (int s = 1; s <= NG; s++) begin
                if (w_ld[s]) r_v[s] <= r_v[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NG; s++) begin
                r_gp[s] <= '0;
                r_p[s]  <= '0;
                r_c0[s] <= 1'b0;
            end
        end else begin
            if (w_ld[0] & w_take) begin
                r_gp[0] <= w_gp0;
                r_p[0]  <= bus.a ^ w_beff;
                r_c0[0] <= w_c0;
            end
            for (int s = 1; s < NG; s++) begin
                if (w_ld[s] & r_v[s-1]) begin
                    r_gp[s] <= w_out[s*REG_EVERY-1];
                    r_p[s]  <= r_p[s-1];
                    r_c0[s] <= r_c0[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
`ifdef PREFIX_ADDER_FLAGS_EN
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
`endif
        end else if (w_ld[NG] & r_v[NG-1]) begin
            r_sum  <= w_sum;
            r_cout <= w_c[WIDTH-1];
            r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH-2];
`ifdef PREFIX_ADDER_FLAGS_EN
            r_zero <= ~|w_sum;
            r_neg  <= w_sum[WIDTH-1];
`endif
        end
    end

    assign bus.in_ready  = r_init & w_ld[0];
    assign bus.out_valid = r_v[NG];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
`ifdef PREFIX_ADDER_FLAGS_EN
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed, backpressure, reset and randomised sweep bench for the prefix adder.
module tb_pipelined_prefix_adder;

    localparam int W   = 64;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(W)) bus ();

    pipelined_prefix_adder #(.WIDTH(W), .REG_EVERY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic, overflow from operand/result signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin,
                                          input logic sub);
        logic [63:0] m, am, be, s;
        logic [64:0] full;
        logic co, ov;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & m;
        be   = (sub ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, be} + {64'd0, (sub | cin)};
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    // Randomised sweeps on independent instances.
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SW = (g == 0) ? 8 : (g == 1) ? 13 : 64;
        localparam int SR = (g == 0) ? 1 : (g == 1) ? 2 : 6;
        localparam int SL = (g == 0) ? 4 : (g == 1) ? 3 : 2;
        bit done = 1'b0;

        pipelined_prefix_adder_if #(.WIDTH(SW)) sb ();

        pipelined_prefix_adder #(.WIDTH(SW), .REG_EVERY(SR)) u_dut (
            .clk   (clk),
            .rst_n (sw_rst_n),
            .bus   (sb)
        );

        initial begin
            logic [65:0] exp_q[$];
            int          acc_q[$];
            logic [63:0] ra, rb;
            logic        rc, rs, pend;
            logic [65:0] e;
            int          sent, lat;
            sb.in_valid  = 1'b0;
            sb.out_ready = 1'b0;
            sb.a = '0; sb.b = '0; sb.cin = 1'b0; sb.sub = 1'b0;
            ra = '0; rb = '0; rc = 1'b0; rs = 1'b0; pend = 1'b0;
            wait (sw_rst_n);
            for (int ph = 0; ph < 2; ph++) begin
                sent = 0;
                for (int cyc = 0; cyc < 2000 &&
                     (sent < 80 || exp_q.size() > 0); cyc++) begin
                    @(negedge clk);
                    if (!pend) begin
                        if (sent < 80 && $urandom_range(0, 3) != 0) begin
                            ra = ($urandom_range(0, 4) == 0) ? '1 : {$urandom, $urandom};
                            rb = ($urandom_range(0, 4) == 0) ? 64'd1 : {$urandom, $urandom};
                            rc = 1'($urandom_range(0, 1));
                            rs = 1'($urandom_range(0, 1));
                            sb.a = ra[SW-1:0]; sb.b = rb[SW-1:0];
                            sb.cin = rc; sb.sub = rs;
                            sb.in_valid = 1'b1;
                        end else begin
                            sb.in_valid = 1'b0;
                        end
                    end
                    sb.out_ready = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    #1;
                    if (sb.out_valid && sb.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("sw%0d_spurious", g), 128'(1), 128'(0));
                        end else begin
                            e   = exp_q.pop_front();
                            lat = cyc - acc_q.pop_front();
                            chk($sformatf("sw%0d_res", g),
                                128'({sb.ovf, sb.cout, 64'(sb.sum)}), 128'(e));
                            if (ph == 0)
                                chk($sformatf("sw%0d_lat", g), 128'(lat), 128'(SL));
                            else
                                chk($sformatf("sw%0d_latmin", g),
                                    128'(lat >= SL), 128'(1));
                        end
                    end
                    if (sb.in_valid && sb.in_ready) begin
                        exp_q.push_back(model(SW, ra, rb, rc, rs));
                        acc_q.push_back(cyc);
                        sent++;
                        pend = 1'b0;
                    end else begin
                        pend = sb.in_valid;
                    end
                end
                chk($sformatf("sw%0d_drain%0d", g, ph), 128'(exp_q.size()), 128'(0));
            end
            sb.in_valid = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        vec_t        vecs [12];
        logic [63:0] ba [10];
        logic [63:0] bb [10];
        logic        bc [10];
        logic        bs [10];
        logic [65:0] e, prev_val;
        logic        prev_hold;
        int          k, sent, recv, first_full, stale;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        vecs[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        vecs[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                     64'd0, 1'b1, 1'b1};
        vecs[7]  = '{64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};
        vecs[8]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
                     64'h2222_2222_2222_2212, 1'b0, 1'b0};
        vecs[9]  = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0,
                     64'd0, 1'b1, 1'b0};
        vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[11] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

        #12;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_sum", 128'(bus.sum), 128'(0));
        chk("rst_cout", 128'(bus.cout), 128'(0));
        chk("rst_ovf", 128'(bus.ovf), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.a = vecs[i].a; bus.b = vecs[i].b;
            bus.cin = vecs[i].cin; bus.sub = vecs[i].sub;
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            k = 1;
            while (!bus.out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("vec%0d_lat", i), 128'(k), 128'(LAT));
            chk($sformatf("vec%0d_sum", i), 128'(bus.sum), 128'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 128'(bus.cout), 128'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i), 128'(bus.ovf), 128'(vecs[i].ov));
        end

        // Backpressure: 10 ops, consumer stalls for cycles 3..8.
        for (int i = 0; i < 10; i++) begin
            ba[i] = {$urandom, $urandom};
            bb[i] = {$urandom, $urandom};
            bc[i] = 1'(i);
            bs[i] = (i % 3 == 0);
        end
        @(negedge clk);
        sent = 0; recv = 0; first_full = -1; prev_hold = 1'b0; prev_val = '0;
        for (int c = 0; c < 100 && recv < 10; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 8);
            if (sent < 10) begin
                bus.a = ba[sent]; bus.b = bb[sent];
                bus.cin = bc[sent]; bus.sub = bs[sent];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_hold) begin
                chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
                chk("bp_hold_data", 128'({bus.ovf, bus.cout, bus.sum}), 128'(prev_val));
            end
            if (!bus.in_ready && first_full < 0) begin
                first_full = c;
                chk("bp_accepted_at_full", 128'(sent), 128'(4));
            end
            if (bus.out_valid && bus.out_ready) begin
                e = model(64, ba[recv], bb[recv], bc[recv], bs[recv]);
                chk($sformatf("bp_res%0d", recv),
                    128'({bus.ovf, bus.cout, bus.sum}), 128'(e));
                recv++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_val  = {bus.ovf, bus.cout, bus.sum};
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("bp_recv_count", 128'(recv), 128'(10));
        chk("bp_full_cycle", 128'(first_full), 128'(4));

        // Reset with three ops in flight.
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a = 64'(3 + i * 7); bus.b = 64'(4 + i);
            bus.cin = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_pre_valid", 128'(bus.out_valid), 128'(1));
        chk("mid_pre_sum", 128'(bus.sum), 128'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_sum", 128'(bus.sum), 128'(0));
        chk("mid_rst_cout", 128'({bus.cout, bus.ovf}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", 128'(bus.in_ready), 128'(1));
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("mid_no_stale", 128'(stale), 128'(0));

        wait (g_sw[0].done && g_sw[1].done && g_sw[2].done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
